// File: rtl/vram_port_arbiter.sv
// Two-requester arbiter in front of a single-port VRAM: burst-limited ownership,
// round-robin tie-break, combinational grant/routing and one-cycle read-valid return.
module vram_port_arbiter #(
    parameter int ADDR_W    = 11,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              REQ0,
    input  logic              REQ1,
    input  logic              WE0,
    input  logic              WE1,
    input  logic [ADDR_W-1:0] ADDR0,
    input  logic [ADDR_W-1:0] ADDR1,
    input  logic [DATA_W-1:0] WDATA0,
    input  logic [DATA_W-1:0] WDATA1,
    input  logic [3:0]        BE0,
    input  logic [3:0]        BE1,
    output logic              GNT0,
    output logic              GNT1,
    output logic              RVALID0,
    output logic              RVALID1,
    output logic [DATA_W-1:0] RDATA,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [DATA_W-1:0] MEM_WDATA,
    output logic [3:0]        MEM_BE,
    output logic              MEM_WREN,
    output logic              MEM_RDEN,
    input  logic [DATA_W-1:0] MEM_RDATA
);

    localparam logic [1:0] OWN_NONE = 2'd0;
    localparam logic [1:0] OWN_R0   = 2'd1;
    localparam logic [1:0] OWN_R1   = 2'd2;
    localparam logic [7:0] YIELD_AT = 8'(MAX_BURST - 1);

    logic [1:0] owner_reg;
    logic       rr_last_reg;     // 0 = R0 granted last, 1 = R1
    logic [7:0] burst_cnt_reg;
    logic       rvalid0_reg;
    logic       rvalid1_reg;

    logic grant0;
    logic grant1;
    logic at_limit;
    logic same_owner;

    // A saturated count after a long solo burst still counts as "at limit".
    assign at_limit = (burst_cnt_reg >= YIELD_AT);

    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!RESET) begin
            case (owner_reg)
                OWN_R0: begin
                    if (REQ0 && !(REQ1 && at_limit)) grant0 = 1'b1;
                    else if (REQ1)                   grant1 = 1'b1;
                end
                OWN_R1: begin
                    if (REQ1 && !(REQ0 && at_limit)) grant1 = 1'b1;
                    else if (REQ0)                   grant0 = 1'b1;
                end
                default: begin
                    if (REQ0 && REQ1) begin
                        grant0 = rr_last_reg;
                        grant1 = !rr_last_reg;
                    end else begin
                        grant0 = REQ0;
                        grant1 = REQ1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        MEM_ADDR  = '0;
        MEM_WDATA = '0;
        MEM_BE    = '0;
        MEM_WREN  = 1'b0;
        MEM_RDEN  = 1'b0;
        if (grant0) begin
            MEM_ADDR  = ADDR0;
            MEM_WDATA = WDATA0;
            MEM_BE    = BE0;
            MEM_WREN  = WE0;
            MEM_RDEN  = !WE0;
        end else if (grant1) begin
            MEM_ADDR  = ADDR1;
            MEM_WDATA = WDATA1;
            MEM_BE    = BE1;
            MEM_WREN  = WE1;
            MEM_RDEN  = !WE1;
        end
    end

    assign same_owner = (grant0 && (owner_reg == OWN_R0)) ||
                        (grant1 && (owner_reg == OWN_R1));

    always_ff @(posedge CLK) begin
        if (RESET) begin
            owner_reg     <= OWN_NONE;
            rr_last_reg   <= 1'b1;
            burst_cnt_reg <= 8'd0;
            rvalid0_reg   <= 1'b0;
            rvalid1_reg   <= 1'b0;
        end else begin
            rvalid0_reg <= grant0 && !WE0;
            rvalid1_reg <= grant1 && !WE1;
            if (grant0 || grant1) begin
                owner_reg   <= grant0 ? OWN_R0 : OWN_R1;
                rr_last_reg <= grant1;
                if (same_owner)
                    burst_cnt_reg <= (burst_cnt_reg == 8'hFF) ? burst_cnt_reg : burst_cnt_reg + 8'd1;
                else
                    burst_cnt_reg <= 8'd0;
            end else begin
                owner_reg     <= OWN_NONE;
                burst_cnt_reg <= 8'd0;
            end
        end
    end

    // Masked by RESET so a read accepted just before reset never reports valid.
    assign RVALID0 = rvalid0_reg && !RESET;
    assign RVALID1 = rvalid1_reg && !RESET;
    assign RDATA   = MEM_RDATA;
    assign GNT0    = grant0;
    assign GNT1    = grant1;

endmodule
